regfile_wb_arbiter: RTL and testbench

- Shares the single synchronous write port of the 32x32 register file (A3/WD3/EN) between NREQ writeback requesters: ALU, load unit, CSR unit.
- Per-requester valid/ready handshake; one grant per cycle.
- Winning write is registered into an output stage that drives the register file write port one cycle later.
- Writes to x0 are absorbed here, so the register file never sees an enable for address 0.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file writeback path: geometry and requester ids.
package regfile_pkg;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_CSR  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr+1, or fixed lowest-index
// priority when REGFILE_WB_FIXED_PRIO_EN is defined (ptr port then disappears).
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
`ifndef REGFILE_WB_FIXED_PRIO_EN
  input  logic [PW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
`ifdef REGFILE_WB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
`else
    // offset NREQ wraps back to ptr itself, so the last winner is tried last
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ writeback requesters and registers
// the winner onto EN/A3/WD3. Define REGFILE_WB_FIXED_PRIO_EN for fixed priority.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wb_hold,
  output logic                      en,
  output logic [AW-1:0]             a3,
  output logic [DW-1:0]             wd3,
  output logic [15:0]               conflict_cnt
);
  import regfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req_live, gnt;
  logic            any_gnt, multi;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  assign req_live = wb_hold ? '0 : req_valid;

`ifndef REGFILE_WB_FIXED_PRIO_EN
  logic [PW-1:0] ptr, gidx;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_live),
`ifndef REGFILE_WB_FIXED_PRIO_EN
    .ptr (ptr),
`endif
    .gnt (gnt)
  );

  assign req_ready = gnt & {NREQ{rst_n}};

  always_comb begin
    any_gnt  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
`ifndef REGFILE_WB_FIXED_PRIO_EN
    gidx     = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        any_gnt  = 1'b1;
        sel_addr = req_addr[i];
        sel_data = req_data[i];
`ifndef REGFILE_WB_FIXED_PRIO_EN
        gidx     = PW'(i);
`endif
      end
    end
  end

  // contention is measured on raw valids, not on what the arbiter saw
  always_comb begin
    int nv;
    nv = 0;
    for (int i = 0; i < NREQ; i++) nv = nv + int'(req_valid[i]);
    multi = (nv >= 2) && !wb_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      a3           <= '0;
      wd3          <= '0;
      conflict_cnt <= '0;
    end else begin
      // x0 grants complete the handshake but never reach the register file
      en <= any_gnt && (sel_addr != AW'(ZERO_REG));
      if (any_gnt && (sel_addr != AW'(ZERO_REG))) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
      if (multi && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

`ifndef REGFILE_WB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= PW'(NREQ - 1);
    else if (any_gnt) ptr <= gidx;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, grant order, x0 drop, hold, saturation.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wb_hold;
  logic                    en;
  logic [AW-1:0]           a3;
  logic [DW-1:0]           wd3;
  logic [15:0]             conflict_cnt;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_hold      (wb_hold),
    .en           (en),
    .a3           (a3),
    .wd3          (wd3),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_hold = 1'b0;
    req_valid = 3'b111; req_addr = '0; req_data = '0;
    #3;
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_en got %b exp 0", en); end
    tests++; if (a3 !== 5'd0) begin fails++; $display("FAIL reset_a3 got %0d exp 0", a3); end
    tests++; if (wd3 !== 32'd0) begin fails++; $display("FAIL reset_wd3 got %h exp 0", wd3); end
    tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 3'b010; req_addr[1] = 5'd7; req_data[1] = 32'hDEADBEEF;
    #1;
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL single_ready got %b exp 010", req_ready); end
    step();
    req_valid = '0;
    tests++; if (en !== 1'b1) begin fails++; $display("FAIL single_en got %b exp 1", en); end
    tests++; if (a3 !== 5'd7) begin fails++; $display("FAIL single_a3 got %0d exp 7", a3); end
    tests++; if (wd3 !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wd3 got %h exp deadbeef", wd3); end
    step();
    tests++; if (en !== 1'b0 || a3 !== 5'd7) begin fails++; $display("FAIL single_idle got en=%b a3=%0d exp en=0 a3=7", en, a3); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = AW'(i + 1);
      req_data[i] = 32'hA0 + i;
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 3'b001 << (k % 3);
      #1;
      tests++; if (req_ready !== exp_gnt) begin fails++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_gnt); end
      step();
      tests++; if (en !== 1'b1 || a3 !== AW'(k % 3 + 1) || wd3 !== 32'hA0 + (k % 3))
        begin fails++; $display("FAIL rr_write[%0d] got en=%b a3=%0d wd3=%h exp en=1 a3=%0d", k, en, a3, wd3, k % 3 + 1); end
      tests++; if (conflict_cnt !== 16'(k + 1)) begin fails++; $display("FAIL rr_cnt[%0d] got %0d exp %0d", k, conflict_cnt, k + 1); end
    end
  endtask

  task automatic test_reset_mid();
    // en=1 here, all requesters still valid
    #2 rst_n = 1'b0;
    #1;
    tests++; if (en !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0)
      begin fails++; $display("FAIL midrst_out got en=%b a3=%0d wd3=%h exp 0", en, a3, wd3); end
    tests++; if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL midrst_cnt got %0d exp 0", conflict_cnt); end
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL midrst_ready got %b exp 000", req_ready); end
    step();
    tests++; if (en !== 1'b0 || req_ready !== 3'b000) begin fails++; $display("FAIL midrst_held got en=%b ready=%b exp 0", en, req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_x0();
    req_valid = 3'b001; req_addr[0] = 5'd0; req_data[0] = 32'd5;
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL x0_ready got %b exp 001", req_ready); end
    step();
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL x0_en got %b exp 0", en); end
    // pointer now at 0, so requester 1 must win over requester 0
    req_valid = 3'b011; req_addr[0] = 5'd3; req_addr[1] = 5'd4; req_data[1] = 32'h44;
    #1;
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL x0_ptr got %b exp 010", req_ready); end
    step();
    req_valid = '0;
    tests++; if (en !== 1'b1 || a3 !== 5'd4) begin fails++; $display("FAIL x0_next got en=%b a3=%0d exp en=1 a3=4", en, a3); end
    tests++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL x0_cnt got %0d exp 1", conflict_cnt); end
  endtask

  task automatic test_hold();
    wb_hold = 1'b1; req_valid = 3'b101;
    req_addr[2] = 5'd12; req_data[2] = 32'h0C0C;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL hold_ready[%0d] got %b exp 000", k, req_ready); end
      step();
      tests++; if (en !== 1'b0 || conflict_cnt !== 16'd1)
        begin fails++; $display("FAIL hold_out[%0d] got en=%b cnt=%0d exp en=0 cnt=1", k, en, conflict_cnt); end
    end
    wb_hold = 1'b0;
    #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL hold_release got %b exp 100", req_ready); end
    step();
    req_valid = '0;
    tests++; if (en !== 1'b1 || a3 !== 5'd12 || wd3 !== 32'h0C0C || conflict_cnt !== 16'd2)
      begin fails++; $display("FAIL hold_write got en=%b a3=%0d wd3=%h cnt=%0d exp 1/12/0c0c/2", en, a3, wd3, conflict_cnt); end
  endtask

  task automatic test_same_reg();
    req_valid = 3'b011;
    req_addr[0] = 5'd9; req_data[0] = 32'h1111AAAA;
    req_addr[1] = 5'd9; req_data[1] = 32'h2222BBBB;
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL same_first got %b exp 001", req_ready); end
    step();
    req_valid = 3'b010;
    tests++; if (a3 !== 5'd9 || wd3 !== 32'h1111AAAA) begin fails++; $display("FAIL same_w0 got a3=%0d wd3=%h exp 9/1111aaaa", a3, wd3); end
    #1;
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL same_second got %b exp 010", req_ready); end
    step();
    req_valid = '0;
    tests++; if (en !== 1'b1 || wd3 !== 32'h2222BBBB) begin fails++; $display("FAIL same_w1 got en=%b wd3=%h exp 1/2222bbbb", en, wd3); end
    step();
    tests++; if (en !== 1'b0 || wd3 !== 32'h2222BBBB) begin fails++; $display("FAIL same_hold got en=%b wd3=%h exp 0/2222bbbb", en, wd3); end
  endtask

  task automatic test_saturate();
    apply_reset();
    req_valid = 3'b011; req_addr[0] = 5'd1; req_addr[1] = 5'd2;
    @(posedge clk);
    repeat (65533) @(posedge clk);
    #1;
    tests++; if (conflict_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_pre got %h exp fffe", conflict_cnt); end
    repeat (6) @(posedge clk);
    #1;
    tests++; if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got %h exp ffff", conflict_cnt); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_x0();
    test_hold();
    test_same_reg();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
